// File: rtl/sys_tx_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// sys_tx_ctrl : serialises 1-byte read responses / 2-byte ALU results onto
//               the UART TX parallel handshake.                Rev 1.0
// ============================================================================
module sys_tx_ctrl #(
   parameter int DATA_WIDTH = 8,
   parameter int ALU_WIDTH  = 2 * DATA_WIDTH
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [DATA_WIDTH-1:0] RD_DATA,
   input  logic                  RD_DATA_VLD,
   input  logic [ALU_WIDTH-1:0]  ALU_OUT,
   input  logic                  ALU_OUT_VLD,
   input  logic                  TX_BUSY,
   output logic [DATA_WIDTH-1:0] TX_P_DATA,
   output logic                  TX_D_VLD,
   output logic                  CTRL_BUSY,
   output logic [7:0]            DROP_CNT
);

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_HOLD      = 2'd1,
      ST_REQ       = 2'd2,
      ST_WAIT_DONE = 2'd3
   } state_t;

   state_t                state_q;
   logic                  idx_q;
   logic                  last_q;
   logic [ALU_WIDTH-1:0]  buf_q;
   logic [DATA_WIDTH-1:0] tx_data_q;
   logic                  tx_vld_q;
   logic                  busy_q;
   logic [7:0]            drop_q;

   logic [1:0]            w_drop_inc;
   logic [8:0]            w_drop_sum;
   logic [7:0]            drop_d;

   // In IDLE only the losing RD strobe of a collision is rejected.
   always_comb begin
      w_drop_inc = 2'd0;
      if (state_q == ST_IDLE) begin
         w_drop_inc = {1'b0, ALU_OUT_VLD & RD_DATA_VLD};
      end else begin
         w_drop_inc = {1'b0, ALU_OUT_VLD} + {1'b0, RD_DATA_VLD};
      end
      w_drop_sum = {1'b0, drop_q} + {7'b0, w_drop_inc};
      drop_d     = w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q   <= ST_IDLE;
         idx_q     <= 1'b0;
         last_q    <= 1'b0;
         buf_q     <= '0;
         tx_data_q <= '0;
         tx_vld_q  <= 1'b0;
         busy_q    <= 1'b0;
         drop_q    <= 8'd0;
      end else begin
         drop_q <= drop_d;
         case (state_q)
            ST_IDLE: begin
               if (ALU_OUT_VLD || RD_DATA_VLD) begin
                  idx_q  <= 1'b0;
                  last_q <= ~ALU_OUT_VLD;
                  busy_q <= 1'b1;
                  buf_q  <= ALU_OUT_VLD ? ALU_OUT
                                        : {{(ALU_WIDTH-DATA_WIDTH){1'b0}}, RD_DATA};
                  if (!TX_BUSY) begin
                     state_q   <= ST_REQ;
                     tx_vld_q  <= 1'b1;
                     tx_data_q <= ALU_OUT_VLD ? ALU_OUT[DATA_WIDTH-1:0] : RD_DATA;
                  end else begin
                     state_q <= ST_HOLD;
                  end
               end
            end
            // A Busy left over from a previous byte must clear before requesting.
            ST_HOLD: begin
               if (!TX_BUSY) begin
                  state_q   <= ST_REQ;
                  tx_vld_q  <= 1'b1;
                  tx_data_q <= idx_q ? buf_q[2*DATA_WIDTH-1:DATA_WIDTH]
                                     : buf_q[DATA_WIDTH-1:0];
               end
            end
            ST_REQ: begin
               if (TX_BUSY) begin
                  state_q  <= ST_WAIT_DONE;
                  tx_vld_q <= 1'b0;
               end
            end
            ST_WAIT_DONE: begin
               if (!TX_BUSY) begin
                  if (!last_q) begin
                     idx_q     <= 1'b1;
                     last_q    <= 1'b1;
                     state_q   <= ST_REQ;
                     tx_vld_q  <= 1'b1;
                     tx_data_q <= buf_q[2*DATA_WIDTH-1:DATA_WIDTH];
                  end else begin
                     state_q <= ST_IDLE;
                     busy_q  <= 1'b0;
                  end
               end
            end
            default: begin
               state_q  <= ST_IDLE;
               tx_vld_q <= 1'b0;
               busy_q   <= 1'b0;
            end
         endcase
      end
   end

   assign TX_P_DATA = tx_data_q;
   assign TX_D_VLD  = tx_vld_q;
   assign CTRL_BUSY = busy_q;
   assign DROP_CNT  = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_sys_tx_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_sys_tx_ctrl : directed vector table plus hand-written frame sequences.
// ============================================================================
module tb_sys_tx_ctrl;

   logic        CLK = 1'b0;
   logic        RST = 1'b0;
   logic [7:0]  RD_DATA = 8'd0;
   logic        RD_DATA_VLD = 1'b0;
   logic [15:0] ALU_OUT = 16'd0;
   logic        ALU_OUT_VLD = 1'b0;
   logic        TX_BUSY = 1'b0;
   logic [7:0]  TX_P_DATA;
   logic        TX_D_VLD;
   logic        CTRL_BUSY;
   logic [7:0]  DROP_CNT;

   sys_tx_ctrl #(.DATA_WIDTH(8), .ALU_WIDTH(16)) dut (
      .CLK         (CLK),
      .RST         (RST),
      .RD_DATA     (RD_DATA),
      .RD_DATA_VLD (RD_DATA_VLD),
      .ALU_OUT     (ALU_OUT),
      .ALU_OUT_VLD (ALU_OUT_VLD),
      .TX_BUSY     (TX_BUSY),
      .TX_P_DATA   (TX_P_DATA),
      .TX_D_VLD    (TX_D_VLD),
      .CTRL_BUSY   (CTRL_BUSY),
      .DROP_CNT    (DROP_CNT)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic        rst;
      logic        rd_vld;
      logic [7:0]  rd_data;
      logic        alu_vld;
      logic [15:0] alu_data;
      logic        busy;
      logic        e_vld;
      logic [7:0]  e_data;
      logic        e_cb;
      logic [7:0]  e_drop;
   } vec_t;

   localparam int NVEC = 17;
   vec_t vecs [NVEC];

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Drive inputs, let one rising edge pass, sample 1ns later.
   task automatic step(input logic rst, input logic rdv, input logic [7:0] rdd,
                       input logic aluv, input logic [15:0] alud, input logic busy);
      RST = rst; RD_DATA_VLD = rdv; RD_DATA = rdd;
      ALU_OUT_VLD = aluv; ALU_OUT = alud; TX_BUSY = busy;
      @(posedge CLK);
      #1;
   endtask

   task automatic check_all(input string name, input logic vld, input logic [7:0] data,
                            input logic cb, input logic [7:0] drop);
      check({name, ".vld"},  int'(TX_D_VLD),  int'(vld));
      check({name, ".data"}, int'(TX_P_DATA), int'(data));
      check({name, ".cb"},   int'(CTRL_BUSY), int'(cb));
      check({name, ".drop"}, int'(DROP_CNT),  int'(drop));
   endtask

   initial begin
      //            rst rdv rdd    aluv alud      bsy  vld data   cb drop
      vecs[0]  = '{1'b1,1'b1,8'h55,1'b1,16'hBEEF,1'b0, 1'b0,8'h00,1'b0,8'd0};
      vecs[1]  = '{1'b1,1'b1,8'h55,1'b1,16'hBEEF,1'b0, 1'b0,8'h00,1'b0,8'd0};
      vecs[2]  = '{1'b0,1'b0,8'h00,1'b0,16'h0000,1'b0, 1'b0,8'h00,1'b0,8'd0};
      // first ALU frame after reset
      vecs[3]  = '{1'b0,1'b0,8'h00,1'b1,16'h1234,1'b0, 1'b1,8'h34,1'b1,8'd0};
      vecs[4]  = '{1'b0,1'b0,8'h00,1'b0,16'h0000,1'b0, 1'b1,8'h34,1'b1,8'd0};
      vecs[5]  = '{1'b0,1'b0,8'h00,1'b0,16'h0000,1'b1, 1'b0,8'h34,1'b1,8'd0};
      vecs[6]  = '{1'b0,1'b0,8'h00,1'b0,16'h0000,1'b1, 1'b0,8'h34,1'b1,8'd0};
      vecs[7]  = '{1'b0,1'b0,8'h00,1'b0,16'h0000,1'b0, 1'b1,8'h12,1'b1,8'd0};
      vecs[8]  = '{1'b0,1'b0,8'h00,1'b0,16'h0000,1'b1, 1'b0,8'h12,1'b1,8'd0};
      vecs[9]  = '{1'b0,1'b0,8'h00,1'b0,16'h0000,1'b0, 1'b0,8'h12,1'b0,8'd0};
      // contention: ALU wins, RD dropped, then 3 more rejected RD strobes
      vecs[10] = '{1'b0,1'b1,8'h77,1'b1,16'hABCD,1'b0, 1'b1,8'hCD,1'b1,8'd1};
      vecs[11] = '{1'b0,1'b1,8'h77,1'b0,16'h0000,1'b0, 1'b1,8'hCD,1'b1,8'd2};
      vecs[12] = '{1'b0,1'b1,8'h77,1'b0,16'h0000,1'b1, 1'b0,8'hCD,1'b1,8'd3};
      vecs[13] = '{1'b0,1'b1,8'h77,1'b0,16'h0000,1'b1, 1'b0,8'hCD,1'b1,8'd4};
      vecs[14] = '{1'b0,1'b0,8'h00,1'b0,16'h0000,1'b0, 1'b1,8'hAB,1'b1,8'd4};
      vecs[15] = '{1'b0,1'b0,8'h00,1'b0,16'h0000,1'b1, 1'b0,8'hAB,1'b1,8'd4};
      vecs[16] = '{1'b0,1'b0,8'h00,1'b0,16'h0000,1'b0, 1'b0,8'hAB,1'b0,8'd4};

      for (int i = 0; i < NVEC; i++) begin
         step(vecs[i].rst, vecs[i].rd_vld, vecs[i].rd_data,
              vecs[i].alu_vld, vecs[i].alu_data, vecs[i].busy);
         check_all($sformatf("vec%0d", i), vecs[i].e_vld, vecs[i].e_data,
                   vecs[i].e_cb, vecs[i].e_drop);
      end

      // RD frame 0xA5: request held 4 cycles, Busy high 20 cycles.
      step(1'b0, 1'b1, 8'hA5, 1'b0, 16'h0, 1'b0);
      check_all("rd.c0", 1'b1, 8'hA5, 1'b1, 8'd4);
      for (int i = 1; i < 4; i++) begin
         step(1'b0, 1'b0, 8'h00, 1'b0, 16'h0, 1'b0);
         check_all($sformatf("rd.c%0d", i), 1'b1, 8'hA5, 1'b1, 8'd4);
      end
      for (int i = 0; i < 20; i++) begin
         step(1'b0, 1'b0, 8'h00, 1'b0, 16'h0, 1'b1);
         check($sformatf("rd.busy%0d.vld", i), int'(TX_D_VLD), 0);
         check($sformatf("rd.busy%0d.cb", i), int'(CTRL_BUSY), 1);
      end
      step(1'b0, 1'b0, 8'h00, 1'b0, 16'h0, 1'b0);
      check_all("rd.done", 1'b0, 8'hA5, 1'b0, 8'd4);

      // Saturation: 100 rejected RD strobes, one double strobe, then 300 more.
      step(1'b0, 1'b0, 8'h00, 1'b1, 16'h5A6B, 1'b0);
      check_all("sat.cap", 1'b1, 8'h6B, 1'b1, 8'd4);
      for (int i = 0; i < 100; i++) step(1'b0, 1'b1, 8'h11, 1'b0, 16'h0, 1'b0);
      check("sat.104", int'(DROP_CNT), 104);
      step(1'b0, 1'b1, 8'h11, 1'b1, 16'h9999, 1'b0);
      check("sat.dual", int'(DROP_CNT), 106);
      for (int i = 0; i < 300; i++) step(1'b0, 1'b1, 8'h11, 1'b0, 16'h0, 1'b0);
      check("sat.255", int'(DROP_CNT), 255);
      check("sat.vld", int'(TX_D_VLD), 1);
      step(1'b0, 1'b0, 8'h00, 1'b0, 16'h0, 1'b1);
      step(1'b0, 1'b0, 8'h00, 1'b0, 16'h0, 1'b0);
      check_all("sat.b1", 1'b1, 8'h5A, 1'b1, 8'd255);
      step(1'b0, 1'b0, 8'h00, 1'b0, 16'h0, 1'b1);
      step(1'b0, 1'b0, 8'h00, 1'b0, 16'h0, 1'b0);
      check_all("sat.done", 1'b0, 8'h5A, 1'b0, 8'd255);

      // Stale Busy at capture: HOLD until Busy falls.
      step(1'b0, 1'b1, 8'h3C, 1'b0, 16'h0, 1'b1);
      check_all("hold.cap", 1'b0, 8'h5A, 1'b1, 8'd255);
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b0, 8'h00, 1'b0, 16'h0, 1'b1);
         check($sformatf("hold.w%0d.vld", i), int'(TX_D_VLD), 0);
      end
      step(1'b0, 1'b0, 8'h00, 1'b0, 16'h0, 1'b0);
      check_all("hold.req", 1'b1, 8'h3C, 1'b1, 8'd255);
      step(1'b0, 1'b0, 8'h00, 1'b0, 16'h0, 1'b1);
      step(1'b0, 1'b0, 8'h00, 1'b0, 16'h0, 1'b0);
      check_all("hold.done", 1'b0, 8'h3C, 1'b0, 8'd255);

      // Mid-frame reset after byte 0x34 is acknowledged.
      step(1'b0, 1'b0, 8'h00, 1'b1, 16'h1234, 1'b0);
      check_all("mr.b0", 1'b1, 8'h34, 1'b1, 8'd255);
      step(1'b0, 1'b0, 8'h00, 1'b0, 16'h0, 1'b1);
      check_all("mr.ack", 1'b0, 8'h34, 1'b1, 8'd255);
      step(1'b1, 1'b0, 8'h00, 1'b0, 16'h0, 1'b1);
      check_all("mr.rst", 1'b0, 8'h00, 1'b0, 8'd0);
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 1'b0, 8'h00, 1'b0, 16'h0, 1'b0);
         check_all($sformatf("mr.after%0d", i), 1'b0, 8'h00, 1'b0, 8'd0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
